uart_alu_interface: RTL
=======================

// Module: uart_alu_interface
// PURPOSE
//  Downstream consumer of the UART receiver and upstream producer for the UART transmitter.
//  Collects three received bytes in order: operand A, operand B, opcode.
//  Drives them to the external combinational ALU, captures the result, and returns it as one
//  transmitted byte. A gap timeout returns a stalled frame to idle.
// PARAMETERS
//  DBIT     8          data width of bytes, operands and result
//  NB_OP    6          opcode width; taken from rx_data[NB_OP-1:0]
//  TIMEOUT  1_000_000  max clk cycles allowed between bytes of one frame (10 ms @ 100 MHz); 0 = disabled
//  TMR_BIT  20         width of the gap timer; must hold TIMEOUT-1
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-low reset (asserted at 0)
//  rx_done      in   1        one-cycle pulse from UART rx: rx_data is valid
//  rx_data      in   DBIT     received byte
//  tx_done      in   1        one-cycle pulse from UART tx: byte fully sent
//  alu_result   in   DBIT     combinational ALU output
//  alu_a        out  DBIT     registered operand A
//  alu_b        out  DBIT     registered operand B
//  alu_op       out  NB_OP    registered opcode
//  tx_start     out  1        one-cycle pulse requesting transmission of tx_data
//  tx_data      out  DBIT     result byte; held stable from the tx_start cycle until tx_done
//  busy         out  1        1 in EXEC, SEND and WAIT_DONE
//  timeout_err  out  1        one-cycle pulse when a partial frame is abandoned
//  overrun      out  1        one-cycle pulse when rx_done arrives while busy (byte dropped)
// BEHAVIOUR
//  Reset (reset==0, async):
//   - State = WAIT_A; gap timer = 0.
//   - alu_a, alu_b, alu_op, tx_data = 0.
//   - tx_start, busy, timeout_err, overrun = 0.
//   - Reset wins at any point mid-frame or mid-transmit; no tx_start is issued afterwards.
//  FSM (all registered, one transition per clk at most):
//   - WAIT_A:    on rx_done: alu_a <= rx_data; go to WAIT_B; timer <= 0.
//   - WAIT_B:    on rx_done: alu_b <= rx_data; go to WAIT_OP; timer <= 0.
//                Otherwise timer increments.
//   - WAIT_OP:   on rx_done: alu_op <= rx_data[NB_OP-1:0]; go to EXEC.
//                Upper rx_data bits are discarded. Otherwise timer increments.
//   - EXEC:      single cycle for the ALU to settle on the registered operands.
//                tx_data <= alu_result; go to SEND.
//   - SEND:      tx_start = 1 for exactly this cycle; go to WAIT_DONE.
//   - WAIT_DONE: on tx_done: go to WAIT_A. No internal limit on the wait.
//  Latency:
//   - rx_done of the opcode at cycle N -> EXEC at N+1 -> tx_data valid and tx_start high at N+2.
//  Timeout (TIMEOUT != 0, states WAIT_B and WAIT_OP only):
//   - When timer == TIMEOUT-1 and rx_done==0: go to WAIT_A; pulse timeout_err; timer <= 0.
//   - alu_a, alu_b, alu_op keep their values.
//   - rx_done in that same cycle takes priority: byte accepted, no timeout_err.
//  Busy states (EXEC, SEND, WAIT_DONE):
//   - rx_done is ignored (no register changes); overrun pulses in the following cycle.
//   - tx_done outside WAIT_DONE is ignored.
//  Outputs:
//   - alu_a, alu_b and alu_op change only on accepted bytes.
//   - tx_data changes only in EXEC.
// TESTING
//  1. Bytes 0x05, 0x03, op 0x20 (ADD); ALU model returns 0x08.
//     -> tx_start pulses 2 cycles after the 3rd rx_done with tx_data=0x08; busy until tx_done.
//  2. Back-to-back frames {0xFF,0x01,0x20} then {0x0F,0xF0,0x25}; tx_done between them.
//     -> results 0x00 then 0xFF; FSM returns to WAIT_A after each tx_done.
//  3. Send A=0x11 only, then idle TIMEOUT cycles (bench uses TIMEOUT=50).
//     -> timeout_err pulses once at cycle 50; the next byte is captured as alu_a, not alu_b.
//  4. rx_done coincident with timer == TIMEOUT-1 in WAIT_B.
//     -> byte accepted into alu_b; no timeout_err.
//  5. rx_done pulse during WAIT_DONE.
//     -> overrun pulses once; alu_a/alu_b/alu_op/tx_data unchanged.
//  6. reset asserted in WAIT_OP, then in SEND.
//     -> all outputs 0 immediately (async); no tx_start after release.

Source files
------------

// File: rtl/uart_alu_interface.sv
// Frames three received bytes (A, B, opcode) for an external combinational ALU and returns
// the result as one transmitted byte. A stalled partial frame is dropped after a gap timeout.
module uart_alu_interface #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned TIMEOUT = 1_000_000,
    parameter int unsigned TMR_BIT = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_done,
    input  logic [DBIT-1:0]  rx_data,
    input  logic             tx_done,
    input  logic [DBIT-1:0]  alu_result,
    output logic [DBIT-1:0]  alu_a,
    output logic [DBIT-1:0]  alu_b,
    output logic [NB_OP-1:0] alu_op,
    output logic             tx_start,
    output logic [DBIT-1:0]  tx_data,
    output logic             busy,
    output logic             timeout_err,
    output logic             overrun
);

    typedef enum logic [2:0] {
        StWaitA,
        StWaitB,
        StWaitOp,
        StExec,
        StSend,
        StWaitDone
    } state_e;

    localparam bit                 TmoEn   = (TIMEOUT != 0);
    localparam logic [TMR_BIT-1:0] TmrLast = TMR_BIT'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [TMR_BIT-1:0] timer_q, timer_d;
    logic [DBIT-1:0]    a_q, a_d, b_q, b_d, txd_q, txd_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic               tx_start_q, tx_start_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;
    logic               expired;

    assign expired = TmoEn && (timer_q == TmrLast);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        txd_d      = txd_q;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        overrun_d  = 1'b0;
        unique case (state_q)
            StWaitA: begin
                timer_d = '0;
                if (rx_done) begin
                    a_d     = rx_data;
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                // An arriving byte beats an expiring timer in the same cycle.
                if (rx_done) begin
                    b_d     = rx_data;
                    timer_d = '0;
                    state_d = StWaitOp;
                end else if (expired) begin
                    timer_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = StWaitA;
                end else if (TmoEn) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitOp: begin
                if (rx_done) begin
                    op_d    = rx_data[NB_OP-1:0];
                    timer_d = '0;
                    state_d = StExec;
                end else if (expired) begin
                    timer_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = StWaitA;
                end else if (TmoEn) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StExec: begin
                txd_d      = alu_result;
                tx_start_d = 1'b1;
                overrun_d  = rx_done;
                state_d    = StSend;
            end
            StSend: begin
                overrun_d = rx_done;
                state_d   = StWaitDone;
            end
            StWaitDone: begin
                overrun_d = rx_done;
                if (tx_done) begin
                    state_d = StWaitA;
                end
            end
            default: state_d = StWaitA;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StWaitA;
            timer_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            txd_q      <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            txd_q      <= txd_d;
            tx_start_q <= tx_start_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign tx_data     = txd_q;
    assign tx_start    = tx_start_q;
    assign timeout_err = timeout_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q == StExec) || (state_q == StSend) || (state_q == StWaitDone);

endmodule
